// File: rtl/quadrature_decoder_if.sv
// Step/direction counting bus produced by the quadrature decoder.
// Also carries the decoder's own position copy and status flags.
interface quadrature_decoder_if #(
  parameter int POS_WIDTH = 3
);
  logic                 step;
  logic                 direction;
  logic [POS_WIDTH-1:0] position;
  logic                 at_max;
  logic                 at_min;
  logic                 error;

  modport master (
    output step, direction, position,
    output at_max, at_min, error
  );

  modport slave (
    input step, direction, position,
    input at_max, at_min, error
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: sync, glitch filter, Gray decode,
// step/direction pulses and a wrapping position count.
module quadrature_decoder #(
  parameter int POS_WIDTH     = 3,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic clear,
  quadrature_decoder_if.master cnt
);

  localparam logic [3:0] CMAX = 4'(FILTER_CYCLES - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           filt_q, filt_d, filt_old_q;
  logic [1:0][3:0]      cnt_q, cnt_d;
  logic [3:0]           stab_q;
  logic                 step_q, dir_q, err_q;
  logic [POS_WIDTH-1:0] pos_q;
  logic                 stable;
  logic [1:0]           mv;

  // Map {a,b} onto its index in the up cycle 00,10,11,01
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  assign stable = (sync2_q == filt_q)
               && (cnt_q[0] == 4'd0)
               && (cnt_q[1] == 4'd0);

  assign mv = gidx(filt_q) - gidx(filt_old_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_old_q <= '0;
      cnt_q      <= '0;
      stab_q     <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      sync1_q    <= {enc_a, enc_b};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      filt_old_q <= filt_q;
      step_q     <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (!stable) begin
            stab_q <= '0;
          end else if (stab_q == CMAX) begin
            state_q <= RUN;
          end else begin
            stab_q <= stab_q + 4'd1;
          end
        end
        RUN: begin
          if (filt_q != filt_old_q) begin
            unique case (1'b1)
              mv == 2'd1: begin
                step_q <= 1'b1;
                dir_q  <= 1'b1;
                pos_q  <= pos_q + 1'b1;
              end
              mv == 2'd3: begin
                step_q <= 1'b1;
                dir_q  <= 1'b0;
                pos_q  <= pos_q - 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        default: state_q <= INIT;
      endcase
      // clear overrides the count but still lets the step pulse out
      if (clear) begin
        pos_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign cnt.step      = step_q;
  assign cnt.direction = dir_q;
  assign cnt.position  = pos_q;
  assign cnt.error     = err_q;
  assign cnt.at_max    = &pos_q;
  assign cnt.at_min    = ~|pos_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed scenarios plus a
// random legal walk against a sequence-level encoder model.
module tb_quadrature_decoder;

  localparam int LAT = 6;
  localparam logic [1:0] SEQ [4] =
    '{2'b00, 2'b10, 2'b11, 2'b01};

  logic clock = 1'b0;
  logic reset;
  logic enc_a;
  logic enc_b;
  logic clear;

  quadrature_decoder_if #(.POS_WIDTH(3)) bus ();

  quadrature_decoder #(
    .POS_WIDTH(3),
    .FILTER_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .clear(clear),
    .cnt(bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [1:0] m_ab;
  int         m_pos;
  logic       m_dir;
  logic       m_err;

  function automatic int seq_pos(input logic [1:0] ab);
    int p = 0;
    for (int i = 0; i < 4; i++)
      if (SEQ[i] == ab) p = i;
    return p;
  endfunction

  // +1 up, -1 down, 0 no change, 2 illegal jump
  function automatic int kind(input logic [1:0] o,
                              input logic [1:0] n);
    int d;
    d = (seq_pos(n) - seq_pos(o) + 4) % 4;
    case (d)
      0: return 0;
      1: return 1;
      3: return -1;
      default: return 2;
    endcase
  endfunction

  function automatic void model(input logic [1:0] ab);
    int k;
    k = kind(m_ab, ab);
    if (k == 1) begin
      m_pos = (m_pos + 1) % 8;
      m_dir = 1'b1;
    end else if (k == -1) begin
      m_pos = (m_pos + 7) % 8;
      m_dir = 1'b0;
    end else if (k == 2) begin
      m_err = 1'b1;
    end
    m_ab = ab;
  endfunction

  task automatic drive(input logic [1:0] ab, input int hold,
                       input int clr_k, output int nst,
                       output int lat, output logic sdir,
                       output int spos);
    nst  = 0;
    lat  = -1;
    sdir = 1'b0;
    spos = -1;
    {enc_a, enc_b} = ab;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clock);
      #1;
      if (bus.step) begin
        nst++;
        if (lat < 0) begin
          lat  = k;
          sdir = bus.direction;
          spos = int'(bus.position);
        end
      end
      clear = (k == clr_k);
    end
    clear = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    m_pos = 0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    int nst, lat, spos;
    logic sdir;
    reset = 1'b1;
    {enc_a, enc_b} = 2'b11;
    repeat (10) @(posedge clock);
    #1;
    tests++;
    if ({bus.step, bus.direction, bus.error} !== 3'b000) begin
      fails++;
      $display("FAIL rst_flags got %b want 000",
               {bus.step, bus.direction, bus.error});
    end
    tests++;
    if ({bus.position, bus.at_max, bus.at_min} !== 5'b00001) begin
      fails++;
      $display("FAIL rst_pos got %b want 00001",
               {bus.position, bus.at_max, bus.at_min});
    end
    reset = 1'b0;
    m_ab = 2'b11; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
    drive(2'b11, 15, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 0 || bus.error !== 1'b0 || bus.position !== 3'd0) begin
      fails++;
      $display("FAIL rst_release got st=%0d err=%b pos=%0d want 0 0 0",
               nst, bus.error, bus.position);
    end
    // a legal step proves the FSM left INIT
    model(2'b01);
    drive(2'b01, 8, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 1 || lat !== LAT || sdir !== 1'b1 || spos !== m_pos) begin
      fails++;
      $display("FAIL rst_run got st=%0d lat=%0d dir=%b pos=%0d want 1 %0d 1 %0d",
               nst, lat, sdir, spos, LAT, m_pos);
    end
    reset = 1'b1;
    {enc_a, enc_b} = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    m_ab = 2'b00; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_up_seq();
    int nst, lat, spos;
    logic sdir;
    for (int i = 1; i <= 4; i++) begin
      model(SEQ[i % 4]);
      drive(SEQ[i % 4], 8, -1, nst, lat, sdir, spos);
      tests++;
      if (nst !== 1 || lat !== LAT || sdir !== 1'b1 || spos !== i) begin
        fails++;
        $display("FAIL up_%0d got st=%0d lat=%0d dir=%b pos=%0d want 1 %0d 1 %0d",
                 i, nst, lat, sdir, spos, LAT, i);
      end
    end
  endtask

  task automatic test_wrap();
    int nst, lat, spos;
    logic sdir;
    pulse_clear();
    tests++;
    if (bus.position !== 3'd0 || bus.at_min !== 1'b1) begin
      fails++;
      $display("FAIL wrap_clear got pos=%0d min=%b want 0 1",
               bus.position, bus.at_min);
    end
    model(2'b01);
    drive(2'b01, 8, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 1 || sdir !== 1'b0 || spos !== 7 ||
        bus.at_max !== 1'b1 || bus.at_min !== 1'b0) begin
      fails++;
      $display("FAIL wrap_down got st=%0d dir=%b pos=%0d max=%b min=%b want 1 0 7 1 0",
               nst, sdir, spos, bus.at_max, bus.at_min);
    end
    model(2'b00);
    drive(2'b00, 8, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 1 || sdir !== 1'b1 || bus.position !== 3'd0 ||
        bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
      fails++;
      $display("FAIL wrap_up got st=%0d dir=%b pos=%0d min=%b want 1 1 0 1",
               nst, sdir, bus.position, bus.at_min);
    end
  endtask

  task automatic test_glitch();
    int nst, lat, spos;
    logic sdir;
    int p0;
    p0 = int'(bus.position);
    enc_a = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    drive(2'b00, 12, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 0 || int'(bus.position) !== p0 || bus.error !== 1'b0) begin
      fails++;
      $display("FAIL glitch got st=%0d pos=%0d err=%b want 0 %0d 0",
               nst, bus.position, bus.error, p0);
    end
  endtask

  task automatic test_error();
    int nst, lat, spos;
    logic sdir;
    model(2'b11);
    drive(2'b11, 8, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 0 || bus.error !== 1'b1 ||
        int'(bus.position) !== m_pos) begin
      fails++;
      $display("FAIL err_jump got st=%0d err=%b pos=%0d want 0 1 %0d",
               nst, bus.error, bus.position, m_pos);
    end
    pulse_clear();
    tests++;
    if (bus.error !== 1'b0) begin
      fails++;
      $display("FAIL err_clear got %b want 0", bus.error);
    end
    model(2'b01);
    drive(2'b01, 8, -1, nst, lat, sdir, spos);
    model(2'b00);
    drive(2'b00, 8, -1, nst, lat, sdir, spos);
    tests++;
    if (int'(bus.position) !== m_pos || bus.error !== 1'b0) begin
      fails++;
      $display("FAIL err_recover got pos=%0d err=%b want %0d 0",
               bus.position, bus.error, m_pos);
    end
  endtask

  task automatic test_clear_step();
    int nst, lat, spos;
    logic sdir;
    pulse_clear();
    for (int i = 1; i <= 5; i++) begin
      model(SEQ[i % 4]);
      drive(SEQ[i % 4], 8, -1, nst, lat, sdir, spos);
    end
    tests++;
    if (bus.position !== 3'd5) begin
      fails++;
      $display("FAIL cs_setup got pos=%0d want 5", bus.position);
    end
    model(2'b11);
    m_pos = 0;
    drive(2'b11, 8, LAT - 1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 1 || lat !== LAT || sdir !== 1'b1 || spos !== 0) begin
      fails++;
      $display("FAIL cs_same got st=%0d lat=%0d dir=%b pos=%0d want 1 %0d 1 0",
               nst, lat, sdir, spos, LAT);
    end
    {enc_a, enc_b} = 2'b01;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tests++;
    if ({bus.step, bus.direction, bus.error, bus.position,
         bus.at_max, bus.at_min} !== 8'b000_000_01) begin
      fails++;
      $display("FAIL mid_reset got %b want 00000001",
               {bus.step, bus.direction, bus.error, bus.position,
                bus.at_max, bus.at_min});
    end
    m_ab = 2'b01; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
    drive(2'b01, 14, -1, nst, lat, sdir, spos);
    tests++;
    if (nst !== 0 || bus.error !== 1'b0 || bus.position !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset_drop got st=%0d err=%b pos=%0d want 0 0 0",
               nst, bus.error, bus.position);
    end
  endtask

  task automatic test_random();
    int nst, lat, spos, hold, idx, k;
    logic sdir;
    logic [1:0] nab;
    for (int n = 0; n < 40; n++) begin
      idx  = seq_pos(m_ab);
      nab  = $urandom_range(0, 1) ? SEQ[(idx + 1) % 4]
                                  : SEQ[(idx + 3) % 4];
      hold = $urandom_range(7, 12);
      k    = kind(m_ab, nab);
      model(nab);
      drive(nab, hold, -1, nst, lat, sdir, spos);
      tests++;
      if (nst !== 1 || lat !== LAT || sdir !== m_dir ||
          spos !== m_pos || bus.error !== m_err ||
          bus.at_max !== (m_pos == 7) ||
          bus.at_min !== (m_pos == 0)) begin
        fails++;
        $display("FAIL rand_%0d k=%0d got st=%0d lat=%0d dir=%b pos=%0d err=%b want 1 %0d %b %0d %b",
                 n, k, nst, lat, sdir, spos, bus.error,
                 LAT, m_dir, m_pos, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    test_reset();
    test_up_seq();
    test_wrap();
    test_glitch();
    test_error();
    test_clear_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Converts a two-phase quadrature encoder (A/B) into single-cycle step pulses plus a direction bit, and tracks a wrapping position count.
- Synchronizes and glitch-filters both phases, then decodes Gray-code transitions and flags illegal double-phase jumps.
- It is the producing end of the enable/direction up-down counting interface: the step and direction outputs drive an up-down counter directly, and the block also keeps its own position copy.

Parameters:
POS_WIDTH, 3, width of position output; wraps at 2**POS_WIDTH-1
FILTER_CYCLES, 3, consecutive cycles a synchronized phase must differ from its filtered value before the filtered value updates; legal 1..15

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high; all state to reset values on the next rising edge
enc_a  input  1  encoder phase A, asynchronous
enc_b  input  1  encoder phase B, asynchronous
clear  input  1  synchronous: position to 0, error to 0
step  output  1  one-cycle pulse per legal decoded transition
direction  output  1  1 = up, 0 = down; held; valid when step=1
position  output  POS_WIDTH  decoded position, wrapping
at_max  output  1  position == all ones (combinational from position)
at_min  output  1  position == 0 (combinational from position)
error  output  1  sticky; set on illegal transition; cleared by clear or reset

Behaviour:
- Reset values:
  - step=0, direction=0, position=0, error=0; at_max=0 and at_min=1 as a consequence of position=0.
  - Synchronizer flops, filtered phases and filter counters are 0.
  - The state machine goes to INIT.
- Synchronizer: two flops per phase. A phase change before edge N is visible in sync2 at edge N+1.
- Glitch filter, independent per phase:
  - sync2 == filt: counter <= 0.
  - sync2 != filt and counter == FILTER_CYCLES-1: filt <= sync2, counter <= 0.
  - Otherwise: counter increments.
  - A pulse shorter than FILTER_CYCLES cycles never reaches filt.
- State machine INIT:
  - filt is loaded from sync2 (filter rules apply); no decode, no step, no error.
  - Exit to RUN after both phases have been stable (sync2 == filt, counters 0) for FILTER_CYCLES consecutive cycles.
  - A nonzero encoder state at reset therefore never produces an error.
- State machine RUN: decode the old filt {a,b} against the new filt {a,b} on every edge where filt changes. One edge later, step/direction/position/error update.
  - Up sequence: 00->10->11->01->00 (A leads B). Action: step=1, direction=1, position+1; all-ones wraps to 0.
  - Down sequence: the reverse. Action: step=1, direction=0, position-1; 0 wraps to all-ones.
  - Both bits change in the same filt update: error <= 1, step=0, position and direction unchanged.
- direction holds its last value between steps.
- Latency, RUN state: an input edge before clock edge 1 gives a filt update at edge 2+FILTER_CYCLES, and step/position register at edge 3+FILTER_CYCLES (default 6).
- Throughput: at most one step per FILTER_CYCLES+1 cycles per phase. Legal input rate is at least FILTER_CYCLES+2 cycles between phase edges.
- clear:
  - Same edge as a decoded step: clear wins, position=0, step still pulses with correct direction.
  - Same edge as an illegal transition: error=0.
  - clear does not affect the filter or the FSM state.
- Reset asserted mid-operation: all state returns to reset values on that edge and the FSM returns to INIT; a step pending that cycle is dropped.
- Reset has priority over clear.
- position arithmetic is modulo 2**POS_WIDTH; no saturation.

Test Plan:
- Reset with enc_a=1, enc_b=1 held 10 cycles, then release: no step, error=0, position=0, FSM reaches RUN.
- From 00, drive 10, 11, 01, 00, each held 8 cycles: 4 step pulses, direction=1, position 1,2,3,4. The first step lands exactly 6 cycles after enc_a rises.
- Starting at position 0, drive one down transition (00->01): step with direction=0, position=7, at_max=1, at_min=0. Then one up transition: position=0, at_min=1.
- 2-cycle glitch on enc_a with FILTER_CYCLES=3: no step, position and error unchanged.
- Jump 00->11 held 8 cycles: error=1, no step, position unchanged. Then pulse clear: error=0.
- clear in the same cycle as an up step from position 5: step=1, direction=1, position=0. Then reset mid-sequence: all outputs return to reset values next edge.
